// File: rtl/yazmac_obegi.sv
// RISC-V integer register file: 32 x VERI_BIT, two combinational read ports
// with write-first bypass, one write port, x0 hard-wired to zero.
module yazmac_obegi #(
    parameter int VERI_BIT  = 32,
    parameter int ADRES_BIT = 5
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [ADRES_BIT-1:0] oku1_adr_i,
    input  logic [ADRES_BIT-1:0] oku2_adr_i,
    output logic [VERI_BIT-1:0]  oku1_deger_o,
    output logic [VERI_BIT-1:0]  oku2_deger_o,
    input  logic [ADRES_BIT-1:0] yaz_adr_i,
    input  logic [VERI_BIT-1:0]  yaz_deger_i,
    input  logic                 yaz_i
);

    localparam int REG_SAYISI = 2 ** ADRES_BIT;

    logic [VERI_BIT-1:0] kayit [REG_SAYISI];
    logic                yaz_gecerli;

    // A write takes effect only outside reset and never to x0.
    assign yaz_gecerli = rst_i && yaz_i && (yaz_adr_i != '0);

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            kayit <= '{default: '0};
        end else if (yaz_gecerli) begin
            kayit[yaz_adr_i] <= yaz_deger_i;
        end
    end

    // Read mux: reset and x0 force zero; a same-cycle write to the
    // addressed register is forwarded ahead of the stored value.
    function automatic logic [VERI_BIT-1:0] oku(
        input logic                 rst_n,
        input logic                 bypass_en,
        input logic [ADRES_BIT-1:0] adr,
        input logic [ADRES_BIT-1:0] yaz_adr,
        input logic [VERI_BIT-1:0]  yaz_deger,
        input logic [VERI_BIT-1:0]  saklanan
    );
        logic [VERI_BIT-1:0] sonuc;
        sonuc = saklanan;
        if (!rst_n || adr == '0) begin
            sonuc = '0;
        end else if (bypass_en && adr == yaz_adr) begin
            sonuc = yaz_deger;
        end
        return sonuc;
    endfunction

    always_comb begin
        oku1_deger_o = '0;
        oku2_deger_o = '0;
        oku1_deger_o = oku(rst_i, yaz_gecerli, oku1_adr_i, yaz_adr_i,
                           yaz_deger_i, kayit[oku1_adr_i]);
        oku2_deger_o = oku(rst_i, yaz_gecerli, oku2_adr_i, yaz_adr_i,
                           yaz_deger_i, kayit[oku2_adr_i]);
    end

endmodule

// File: tb/tb_yazmac_obegi.sv
// Directed bench for yazmac_obegi: table of per-cycle vectors plus
// hand-written reset / fill sequences.
module tb_yazmac_obegi;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [4:0]  oku1_adr_i, oku2_adr_i, yaz_adr_i;
    logic [31:0] oku1_deger_o, oku2_deger_o, yaz_deger_i;
    logic        yaz_i;

    int passed = 0;
    int total  = 0;

    yazmac_obegi #(.VERI_BIT(32), .ADRES_BIT(5)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .oku1_adr_i   (oku1_adr_i),
        .oku2_adr_i   (oku2_adr_i),
        .oku1_deger_o (oku1_deger_o),
        .oku2_deger_o (oku2_deger_o),
        .yaz_adr_i    (yaz_adr_i),
        .yaz_deger_i  (yaz_deger_i),
        .yaz_i        (yaz_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        rst;
        logic        yaz;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [31:0] e1;
        logic [31:0] e2;
    } vec_t;

    vec_t tbl [15];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    // Drive one cycle's inputs just after a rising edge.
    task automatic drive(input logic r, input logic y, input logic [4:0] wa,
                         input logic [31:0] wd, input logic [4:0] a1, input logic [4:0] a2);
        @(posedge clk_i);
        #1;
        rst_i = r; yaz_i = y; yaz_adr_i = wa; yaz_deger_i = wd;
        oku1_adr_i = a1; oku2_adr_i = a2;
        @(negedge clk_i);
    endtask

    initial begin
        rst_i = 1'b0; yaz_i = 1'b0; yaz_adr_i = '0; yaz_deger_i = '0;
        oku1_adr_i = '0; oku2_adr_i = '0;

        //            rst  yaz  wa  wd            a1  a2  e1            e2
        tbl[0]  = '{1'b0, 1'b1, 4,  32'h99,       0,  4,  32'h0,        32'h0};
        tbl[1]  = '{1'b1, 1'b0, 0,  32'h0,        4,  31, 32'h0,        32'h0};
        tbl[2]  = '{1'b1, 1'b1, 5,  32'hDEADBEEF, 5,  1,  32'hDEADBEEF, 32'h0};
        tbl[3]  = '{1'b1, 1'b0, 0,  32'h0,        5,  5,  32'hDEADBEEF, 32'hDEADBEEF};
        tbl[4]  = '{1'b1, 1'b1, 0,  32'hFFFFFFFF, 0,  0,  32'h0,        32'h0};
        tbl[5]  = '{1'b1, 1'b0, 0,  32'h0,        0,  5,  32'h0,        32'hDEADBEEF};
        tbl[6]  = '{1'b1, 1'b1, 7,  32'hA,        7,  3,  32'hA,        32'h0};
        tbl[7]  = '{1'b1, 1'b1, 7,  32'h12345678, 3,  7,  32'h0,        32'h12345678};
        tbl[8]  = '{1'b1, 1'b0, 0,  32'h0,        7,  7,  32'h12345678, 32'h12345678};
        tbl[9]  = '{1'b1, 1'b0, 10, 32'h55,       10, 10, 32'h0,        32'h0};
        tbl[10] = '{1'b1, 1'b0, 0,  32'h0,        10, 7,  32'h0,        32'h12345678};
        tbl[11] = '{1'b1, 1'b1, 3,  32'h33,       3,  3,  32'h33,       32'h33};
        tbl[12] = '{1'b1, 1'b1, 9,  32'h99,       3,  5,  32'h33,       32'hDEADBEEF};
        tbl[13] = '{1'b0, 1'b1, 9,  32'h77,       9,  3,  32'h0,        32'h0};
        tbl[14] = '{1'b1, 1'b0, 0,  32'h0,        9,  3,  32'h0,        32'h0};

        // Reset, then every address reads zero on both ports.
        drive(1'b0, 1'b0, 0, 0, 0, 0);
        for (int i = 0; i < 32; i++) begin
            drive(1'b1, 1'b0, 0, 0, 5'(i), 5'(31 - i));
            chk($sformatf("rst_rd1_x%0d", i), oku1_deger_o, 32'h0);
            chk($sformatf("rst_rd2_x%0d", 31 - i), oku2_deger_o, 32'h0);
        end

        for (int v = 0; v < 15; v++) begin
            drive(tbl[v].rst, tbl[v].yaz, tbl[v].wa, tbl[v].wd, tbl[v].a1, tbl[v].a2);
            chk($sformatf("vec%0d_rd1", v), oku1_deger_o, tbl[v].e1);
            chk($sformatf("vec%0d_rd2", v), oku2_deger_o, tbl[v].e2);
        end

        // Fill x1..x31 with 1..31 and read them back.
        for (int i = 1; i < 32; i++) drive(1'b1, 1'b1, 5'(i), 32'(i), 0, 0);
        for (int i = 0; i < 32; i++) begin
            drive(1'b1, 1'b0, 0, 0, 5'(i), 5'(31 - i));
            chk($sformatf("fill_rd1_x%0d", i), oku1_deger_o, 32'(i));
            chk($sformatf("fill_rd2_x%0d", 31 - i), oku2_deger_o, 32'(31 - i));
        end

        // Mid-operation reset with a competing write to x4: reset wins.
        drive(1'b0, 1'b1, 4, 32'h99, 4, 4);
        chk("midrst_rd1", oku1_deger_o, 32'h0);
        chk("midrst_rd2", oku2_deger_o, 32'h0);
        for (int i = 0; i < 32; i++) begin
            drive(1'b1, 1'b0, 0, 0, 5'(i), 5'(31 - i));
            chk($sformatf("postrst_rd1_x%0d", i), oku1_deger_o, 32'h0);
            chk($sformatf("postrst_rd2_x%0d", 31 - i), oku2_deger_o, 32'h0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/yazmac_obegi.md
YAZMAC_OBEGI -- requirements
Module: yazmac_obegi

Interface
REQ-001 The block SHALL have the parameter VERI_BIT, default 32, giving the register data width.
REQ-002 The block SHALL have the parameter ADRES_BIT, default 5, giving the address width; register count = 2**ADRES_BIT (32).
REQ-003 The block SHALL have the port clk_i, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 The block SHALL have the port rst_i, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have the port oku1_adr_i, input, 5 bits: read port 1 address (rs1).
REQ-006 The block SHALL have the port oku2_adr_i, input, 5 bits: read port 2 address (rs2).
REQ-007 The block SHALL have the port oku1_deger_o, output, 32 bits: read port 1 data.
REQ-008 The block SHALL have the port oku2_deger_o, output, 32 bits: read port 2 data.
REQ-009 The block SHALL have the port yaz_adr_i, input, 5 bits: write address (rd).
REQ-010 The block SHALL have the port yaz_deger_i, input, 32 bits: write data.
REQ-011 The block SHALL have the port yaz_i, input, 1 bit: write enable, active-high.

Function
REQ-012 Storage SHALL be 32 registers x 32 bits (RISC-V x0..x31).
REQ-013 Register x0 SHALL always read as 0; writes to address 0 SHALL be discarded with no side effect.
REQ-014 On a rising edge with rst_i=1, yaz_i=1 and yaz_adr_i!=0, register[yaz_adr_i] SHALL take yaz_deger_i.
REQ-015 Writes SHALL have one-cycle latency: the stored value is visible from the cycle after the write edge.
REQ-016 With yaz_i=0, no register SHALL change.
REQ-017 Both read ports SHALL be combinational (zero-cycle), independent, and may address the same register simultaneously.
REQ-018 Write-first bypass: when rst_i=1, yaz_i=1, yaz_adr_i!=0 and yaz_adr_i equals a read address, that read port SHALL output yaz_deger_i in the same cycle.
REQ-019 Bypass SHALL apply to each port independently; both ports SHALL bypass when both match.
REQ-020 A write to address 0 SHALL never be bypassed; a read of address 0 SHALL return 0.
REQ-021 Reads of non-matching addresses SHALL return stored contents, unaffected by a concurrent write.
REQ-022 There SHALL be no X propagation from storage after the first reset edge; all addresses are valid (no out-of-range case).

Reset
REQ-023 On a rising edge with rst_i=0, all 32 registers SHALL be cleared to 0x00000000.
REQ-024 A write presented in a reset cycle SHALL be ignored; reset wins over write.
REQ-025 While rst_i=0, both read outputs SHALL be 0 and bypass SHALL be disabled.
REQ-026 Contents before the first reset edge SHALL be undefined; reset SHALL be assertable mid-operation with the same effect.

Verification
REQ-027 Reset, then read all 32 addresses on both ports -> every read returns 0x00000000.
REQ-028 Write x5=0xDEADBEEF, next cycle oku1_adr_i=5, oku2_adr_i=5 -> both outputs 0xDEADBEEF.
REQ-029 yaz_i=1, yaz_adr_i=0, yaz_deger_i=0xFFFFFFFF, oku1_adr_i=0 -> oku1_deger_o=0 in that cycle and afterwards.
REQ-030 yaz_i=1, yaz_adr_i=7, yaz_deger_i=0x12345678, oku2_adr_i=7 (x7 holds 0xA) -> oku2_deger_o=0x12345678 in the same cycle (bypass); oku1_adr_i=3 is unaffected.
REQ-031 Write x10=0x55 with yaz_i=0 -> x10 remains at its previous value.
REQ-032 Fill x1..x31 with the values 1..31, assert rst_i=0 for one edge together with a write of x4=0x99 -> all registers read 0, including x4.
